// File: rtl/servo_frame_scheduler_if.sv
// Command channel between a position source and the servo frame scheduler:
// valid/ready handshake carrying a channel index and a target angle, plus a clamp-error pulse.
interface servo_frame_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    logic [7:0] cmd_pos;
    logic       cmd_err;

    modport master (output cmd_valid, cmd_ch, cmd_pos, input cmd_ready, cmd_err);
    modport slave  (input cmd_valid, cmd_ch, cmd_pos, output cmd_ready, cmd_err);
endinterface

// File: rtl/servo_frame_scheduler.sv
// Per-frame servo position scheduler: latches commanded targets and, once per frame,
// slews every channel's current position toward its target by at most MAX_STEP degrees.
module servo_frame_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int FRAME_CYCLES = 1000000,
    parameter int MAX_STEP     = 4,
    parameter int INIT_POS     = 90
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    servo_frame_scheduler_if.slave  cmd,
    output logic [8*NUM_CH-1:0]     pos_out,
    output logic                    frame_tick
);

    localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] MAX_POS = 8'd180;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick_q, tick_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [7:0]       target_q [NUM_CH];
    logic [7:0]       target_d [NUM_CH];
    logic [7:0]       cur_q    [NUM_CH];
    logic [7:0]       cur_d    [NUM_CH];
    logic             accept;

    // 9-bit difference so neither direction can wrap; target is already clamped to 180.
    function automatic logic [7:0] slew(input logic [7:0] tgt, input logic [7:0] pos);
        logic [8:0] diff;
        logic [8:0] step;
        if (tgt >= pos) diff = {1'b0, tgt} - {1'b0, pos};
        else            diff = {1'b0, pos} - {1'b0, tgt};
        step = (diff > 9'(MAX_STEP)) ? 9'(MAX_STEP) : diff;
        if (tgt >= pos) slew = 8'({1'b0, pos} + step);
        else            slew = 8'({1'b0, pos} - step);
    endfunction

    assign accept = cmd.cmd_valid && ready_q;

    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(FRAME_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
        // Tick is registered, so it is high while the counter sits at its last value.
        tick_d = (cnt_d == CNT_W'(FRAME_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick_q && enable) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (int'(idx_q) == NUM_CH - 1) state_d = IDLE;
                else                           idx_d   = idx_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        err_d   = accept && (cmd.cmd_pos > MAX_POS);
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            target_d[k] = target_q[k];
            cur_d[k]    = cur_q[k];
            if (accept && int'(cmd.cmd_ch) == k)
                target_d[k] = (cmd.cmd_pos > MAX_POS) ? MAX_POS : cmd.cmd_pos;
            if (state_q == UPDATE && int'(idx_q) == k)
                cur_d[k] = slew(target_q[k], cur_q[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= 8'(INIT_POS);
                cur_q[k]    <= 8'(INIT_POS);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= target_d[k];
                cur_q[k]    <= cur_d[k];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign pos_out[8*gi +: 8] = cur_q[gi];
        end
    endgenerate

    assign frame_tick    = tick_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.cmd_err   = err_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Randomized bench for servo_frame_scheduler against a cycle-indexed behavioural model
// of frames, sweep windows, targets and positions.
module tb_servo_frame_scheduler;

    localparam int NUM_CH = 4;
    localparam int FC     = 100;
    localparam int STEP   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [8*NUM_CH-1:0] pos_out;
    logic frame_tick;

    servo_frame_scheduler_if cmd_if ();

    servo_frame_scheduler #(
        .NUM_CH(NUM_CH), .FRAME_CYCLES(FC), .MAX_STEP(STEP), .INIT_POS(90)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cmd(cmd_if),
        .pos_out(pos_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: cycle index since reset release, start cycle of the current sweep.
    int m_c;
    int m_sweep_start;
    int m_tgt [NUM_CH];
    int m_cur [NUM_CH];
    bit m_err_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, m_c, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return (m_c > 0) && !(m_c >= m_sweep_start && m_c < m_sweep_start + NUM_CH);
    endfunction

    function automatic logic [8*NUM_CH-1:0] exp_pos();
        logic [8*NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[8*k +: 8] = 8'(m_cur[k]);
        return v;
    endfunction

    task automatic model_reset();
        m_c = 0;
        m_sweep_start = -1000;
        m_err_exp = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_tgt[k] = 90;
            m_cur[k] = 90;
        end
    endtask

    // Inputs for this cycle are already driven; check outputs, advance model, step clock.
    task automatic cycle();
        bit acc;
        bit tick;
        int k;
        tick = ((m_c % FC) == FC - 1);
        check("frame_tick", 64'(frame_tick), 64'(tick));
        check("cmd_ready", 64'(cmd_if.cmd_ready), 64'(exp_ready()));
        check("cmd_err", 64'(cmd_if.cmd_err), 64'(m_err_exp));
        check("pos_out", 64'(pos_out), 64'(exp_pos()));
        acc = cmd_if.cmd_valid && exp_ready();
        m_err_exp = acc && (cmd_if.cmd_pos > 8'd180);
        if (acc) m_tgt[cmd_if.cmd_ch] = (cmd_if.cmd_pos > 8'd180) ? 180 : int'(cmd_if.cmd_pos);
        k = m_c - m_sweep_start;
        if (k >= 0 && k < NUM_CH) begin
            if (m_tgt[k] > m_cur[k])      m_cur[k] += (m_tgt[k] - m_cur[k] < STEP) ? m_tgt[k] - m_cur[k] : STEP;
            else if (m_tgt[k] < m_cur[k]) m_cur[k] -= (m_cur[k] - m_tgt[k] < STEP) ? m_cur[k] - m_tgt[k] : STEP;
        end
        if (tick && enable) m_sweep_start = m_c + 1;
        m_c++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pos", 64'(pos_out), 64'({NUM_CH{8'd90}}));
        check("rst_ready", 64'(cmd_if.cmd_ready), 64'd0);
        check("rst_tick", 64'(frame_tick), 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input int ch, input int pos);
        bit a;
        int guard = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch = 2'(ch);
        cmd_if.cmd_pos = 8'(pos);
        do begin
            a = exp_ready();
            cycle();
            guard++;
        end while (!a && guard < 50);
        if (!a) check("send_timeout", 64'(guard), 64'd0);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic run_frames(input int n, input bit en);
        enable = en;
        repeat (n * FC) cycle();
    endtask

    initial begin
        int guard;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch = 2'd0;
        cmd_if.cmd_pos = 8'd0;
        @(negedge clk);
        do_reset();

        // Idle frames: positions stay at 90, tick every FC cycles.
        run_frames(5, 1'b1);

        send(0, 100);
        run_frames(4, 1'b1);
        check("lane0_settled", 64'(pos_out[7:0]), 64'd100);

        send(2, 200);
        run_frames(25, 1'b1);
        check("lane2_saturated", 64'(pos_out[23:16]), 64'd180);

        enable = 1'b0;
        send(1, 0);
        run_frames(3, 1'b0);
        check("lane1_hold", 64'(pos_out[15:8]), 64'd90);
        run_frames(4, 1'b1);

        // Valid held high across frame boundaries with a fresh command every cycle.
        cmd_if.cmd_valid = 1'b1;
        for (int i = 0; i < 3 * FC; i++) begin
            cmd_if.cmd_ch = 2'($urandom_range(0, 3));
            cmd_if.cmd_pos = 8'($urandom_range(0, 255));
            cycle();
        end
        cmd_if.cmd_valid = 1'b0;

        // Sparse random commands with occasional enable toggles.
        for (int i = 0; i < 30 * FC; i++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 5) == 0);
            cmd_if.cmd_ch = 2'($urandom_range(0, 3));
            cmd_if.cmd_pos = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            cycle();
        end
        cmd_if.cmd_valid = 1'b0;

        // Reset in the middle of a sweep, after lane 0 has moved.
        do_reset();
        enable = 1'b1;
        send(0, 0);
        guard = 0;
        while (m_c != m_sweep_start + 1 && guard < 3 * FC) begin
            cycle();
            guard++;
        end
        check("sweep_reached", 64'(m_c == m_sweep_start + 1), 64'd1);
        check("lane0_moved", 64'(pos_out[7:0]), 64'd86);
        rst = 1'b1;
        #1;
        check("async_rst_pos", 64'(pos_out), 64'({NUM_CH{8'd90}}));
        check("async_rst_ready", 64'(cmd_if.cmd_ready), 64'd0);
        check("async_rst_err", 64'(cmd_if.cmd_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_frames(3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
